// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF coprocessor execute stage: decoded ops,
// writeback payload, memory request and the FSM state encoding.
package fir_xifu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 12;

  localparam logic [1:0] PRIV_MACHINE = 2'b11;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [3:0] BE_WORD      = 4'hF;

  typedef enum logic [1:0] {
    INSTR_NONE     = 2'd0,
    INSTR_XFIRLW   = 2'd1,
    INSTR_XFIRSW   = 2'd2,
    INSTR_XFIRDOTP = 2'd3
  } fir_xifu_instr_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } fir_xifu_state_e;

  typedef struct packed {
    fir_xifu_instr_e   instr;
    logic [ID_W-1:0]   id;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   rs1_val;
    logic [IMM_W-1:0]  imm;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   wdata;
  } fir_xifu_id2ex_t;

  typedef struct packed {
    fir_xifu_instr_e   instr;
    logic [ID_W-1:0]   id;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   result;
  } fir_xifu_ex2wb_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [XLEN-1:0]   addr;
    logic [1:0]        mode;
    logic              we;
    logic [2:0]        size;
    logic [3:0]        be;
    logic [1:0]        attr;
    logic [XLEN-1:0]   wdata;
    logic              last;
    logic              spec;
  } x_mem_req_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  // Word access at the unincremented base address; store data only for XFIRSW.
  function automatic x_mem_req_t build_mem_req(input fir_xifu_id2ex_t op);
    x_mem_req_t req;
    req       = '0;
    req.id    = op.id;
    req.addr  = op.rs1_val;
    req.mode  = PRIV_MACHINE;
    req.we    = (op.instr == INSTR_XFIRSW);
    req.size  = SIZE_WORD;
    req.be    = BE_WORD;
    req.attr  = 2'b00;
    req.wdata = (op.instr == INSTR_XFIRSW) ? op.wdata : '0;
    req.last  = 1'b1;
    req.spec  = 1'b0;
    return req;
  endfunction

endpackage

// File: rtl/cv32e40x_if_xif.sv
// Minimal eXtension-interface memory request channel used by the execute stage.
interface cv32e40x_if_xif;
  import fir_xifu_pkg::*;

  logic       mem_valid;
  logic       mem_ready;
  x_mem_req_t mem_req;

  modport coproc_mem (output mem_valid, output mem_req, input mem_ready);
  modport cpu_mem    (input mem_valid, input mem_req, output mem_ready);
endinterface

// File: rtl/fir_xifu_dotp.sv
// Combinational Q-format dual 16-bit dot product with accumulate.
module fir_xifu_dotp
  import fir_xifu_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 15
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned PW = 33;

  logic signed [PW-1:0] a_lo, a_hi, b_lo, b_hi;
  logic signed [PW-1:0] p_lo, p_hi, sum, shifted;

  // 33 bits holds the one overflow case: (-32768)^2 + (-32768)^2 = 2^31.
  always_comb begin
    a_lo     = PW'($signed(op_a[15:0]));
    a_hi     = PW'($signed(op_a[31:16]));
    b_lo     = PW'($signed(op_b[15:0]));
    b_hi     = PW'($signed(op_b[31:16]));
    p_lo     = a_lo * b_lo;
    p_hi     = a_hi * b_hi;
    sum      = p_lo + p_hi;
    shifted  = sum >>> FRAC_BITS;
    result_c = acc + XLEN'(shifted);
  end

endmodule

// File: rtl/fir_xifu_ex.sv
// Execute stage of the FIR XIF coprocessor: single-cycle dot product and
// post-increment load/store issuing one memory request per instruction.
module fir_xifu_ex
  import fir_xifu_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  fir_xifu_id2ex_t          id2ex_i,
  input  logic                     id_valid_i,
  output logic                     ex_ready_o,
  cv32e40x_if_xif.coproc_mem       xif_mem_o,
  input  logic                     mem_result_valid_i,
  output fir_xifu_ex2wb_t          ex2wb_o
);

  fir_xifu_state_e state;
  x_mem_req_t      mem_req;
  logic [XLEN-1:0] dotp_result_c;
  logic            accept_c;

  fir_xifu_dotp #(.FRAC_BITS(FRAC_BITS)) u_dotp (
    .op_a     (id2ex_i.op_a),
    .op_b     (id2ex_i.op_b),
    .acc      (id2ex_i.acc),
    .result_c (dotp_result_c)
  );

  // Ready in the completion cycle of MEM_WAIT allows back-to-back issue.
  assign ex_ready_o = (state == IDLE) || ((state == MEM_WAIT) && mem_result_valid_i);
  assign accept_c   = id_valid_i && ex_ready_o;

  assign xif_mem_o.mem_valid = (state == MEM_REQ);
  assign xif_mem_o.mem_req   = mem_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      ex2wb_o       <= '0;
      ex2wb_o.instr <= INSTR_NONE;
      mem_req       <= '0;
    end else begin
      case (state)
        MEM_REQ: begin
          if (xif_mem_o.mem_ready) state <= MEM_WAIT;
        end
        default: begin
          // IDLE, or MEM_WAIT in its completion cycle
          if (ex_ready_o) begin
            state <= IDLE;
            if (accept_c) begin
              case (id2ex_i.instr)
                INSTR_XFIRDOTP: begin
                  ex2wb_o.instr  <= INSTR_XFIRDOTP;
                  ex2wb_o.id     <= id2ex_i.id;
                  ex2wb_o.rs1    <= id2ex_i.rs1;
                  ex2wb_o.rd     <= id2ex_i.rd;
                  ex2wb_o.result <= dotp_result_c;
                end
                INSTR_XFIRLW, INSTR_XFIRSW: begin
                  ex2wb_o.instr  <= id2ex_i.instr;
                  ex2wb_o.id     <= id2ex_i.id;
                  ex2wb_o.rs1    <= id2ex_i.rs1;
                  ex2wb_o.rd     <= id2ex_i.rd;
                  ex2wb_o.result <= id2ex_i.rs1_val + sext_imm(id2ex_i.imm);
                  mem_req        <= build_mem_req(id2ex_i);
                  state          <= MEM_REQ;
                end
                default: ex2wb_o.instr <= INSTR_NONE;
              endcase
            end else if (state == IDLE) begin
              ex2wb_o.instr <= INSTR_NONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Scoreboard bench for fir_xifu_ex: dot product, load/store handshakes,
// back-to-back issue, address wrap and reset abandonment.
module tb_fir_xifu_ex;
  import fir_xifu_pkg::*;

  localparam int unsigned FRAC = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  fir_xifu_id2ex_t id2ex;
  logic            id_valid;
  logic            mem_result_valid;
  logic            ex_ready, ex_ready0;
  fir_xifu_ex2wb_t ex2wb, ex2wb0;

  cv32e40x_if_xif xif ();
  cv32e40x_if_xif xif0 ();
  assign xif0.mem_ready = xif.mem_ready;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int hs_exp = 0;
  fir_xifu_ex2wb_t exp_q[$];

  always #5 clk = ~clk;

  fir_xifu_ex #(.FRAC_BITS(FRAC)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .id2ex_i            (id2ex),
    .id_valid_i         (id_valid),
    .ex_ready_o         (ex_ready),
    .xif_mem_o          (xif),
    .mem_result_valid_i (mem_result_valid),
    .ex2wb_o            (ex2wb)
  );

  fir_xifu_ex #(.FRAC_BITS(0)) dut0 (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .id2ex_i            (id2ex),
    .id_valid_i         (id_valid),
    .ex_ready_o         (ex_ready0),
    .xif_mem_o          (xif0),
    .mem_result_valid_i (mem_result_valid),
    .ex2wb_o            (ex2wb0)
  );

  always @(negedge clk) begin
    if (rst_n && xif.mem_valid && xif.mem_ready) hs_cnt <= hs_cnt + 1;
  end

  function automatic logic [31:0] dotp_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] acc, input int unsigned frac);
    longint s;
    s = longint'($signed(a[15:0])) * longint'($signed(b[15:0]))
      + longint'($signed(a[31:16])) * longint'($signed(b[31:16]));
    s = s >>> frac;
    return acc + s[31:0];
  endfunction

  function automatic x_mem_req_t exp_req(input fir_xifu_id2ex_t op);
    x_mem_req_t r;
    r       = '0;
    r.id    = op.id;
    r.addr  = op.rs1_val;
    r.mode  = 2'b11;
    r.we    = (op.instr == INSTR_XFIRSW);
    r.size  = 3'b010;
    r.be    = 4'hF;
    r.wdata = r.we ? op.wdata : 32'h0;
    r.last  = 1'b1;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fir_xifu_instr_e instr, input logic [31:0] rs1_val,
                       input logic [11:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] acc, input logic [31:0] wdata);
    fir_xifu_ex2wb_t e;
    id2ex.instr   = instr;
    id2ex.id      = 4'($urandom);
    id2ex.rs1     = 5'($urandom);
    id2ex.rd      = 5'($urandom);
    id2ex.rs1_val = rs1_val;
    id2ex.imm     = imm;
    id2ex.op_a    = a;
    id2ex.op_b    = b;
    id2ex.acc     = acc;
    id2ex.wdata   = wdata;
    id_valid      = 1'b1;
    e.instr = instr;
    e.id    = id2ex.id;
    e.rs1   = id2ex.rs1;
    e.rd    = id2ex.rd;
    if (instr == INSTR_XFIRDOTP) begin
      e.result = dotp_model(a, b, acc, FRAC);
      exp_q.push_back(e);
    end else if (instr == INSTR_XFIRLW || instr == INSTR_XFIRSW) begin
      e.result = rs1_val + {{20{imm[11]}}, imm};
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; id_valid = 1'b0; mem_result_valid = 1'b0; xif.mem_ready = 1'b0; id2ex = '0;
    repeat (2) tick;
    n_vec++;
    if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ex_ready); end
    n_vec++;
    if (xif.mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %b expected 0", xif.mem_valid); end
    n_vec++;
    if (ex2wb !== '0) begin n_err++; $display("FAIL reset_ex2wb: got %h expected 0", ex2wb); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_dotp;
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [31:0] tc [8];
    fir_xifu_ex2wb_t e;
    // 3*5 + 2*4 + 0x10 = 0x27 with no fractional shift
    ta[0] = 32'h0002_0003; tb[0] = 32'h0004_0005; tc[0] = 32'h10;
    ta[1] = 32'h8000_8000; tb[1] = 32'h8000_8000; tc[1] = 32'h0;
    ta[2] = 32'hFFFE_0003; tb[2] = 32'h0007_0002; tc[2] = 32'h5;
    ta[3] = 32'h7FFF_7FFF; tb[3] = 32'h7FFF_7FFF; tc[3] = 32'hFFFF_FFFF;
    for (int i = 4; i < 8; i++) begin ta[i] = $urandom; tb[i] = $urandom; tc[i] = $urandom; end
    for (int i = 0; i < 8; i++) begin
      drive(INSTR_XFIRDOTP, $urandom, 12'($urandom), ta[i], tb[i], tc[i], $urandom);
      tick;
      e = exp_q.pop_front();
      n_vec++;
      if (ex2wb !== e) begin n_err++; $display("FAIL dotp_q15[%0d]: got %h expected %h", i, ex2wb, e); end
      n_vec++;
      if (ex2wb0.result !== dotp_model(ta[i], tb[i], tc[i], 0)) begin
        n_err++; $display("FAIL dotp_q0[%0d]: got %h expected %h", i, ex2wb0.result, dotp_model(ta[i], tb[i], tc[i], 0));
      end
      n_vec++;
      if (xif.mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
        n_err++; $display("FAIL dotp_idle[%0d]: got valid=%b ready=%b expected valid=0 ready=1", i, xif.mem_valid, ex_ready);
      end
    end
    id_valid = 1'b0;
    tick;
    n_vec++;
    if (ex2wb.instr !== INSTR_NONE || ex2wb.result !== e.result) begin
      n_err++; $display("FAIL idle_clear: got %h expected instr=NONE result=%h", ex2wb, e.result);
    end
  endtask

  task automatic test_mem(input fir_xifu_instr_e instr, input logic [31:0] rs1_val,
                          input logic [11:0] imm, input int stall, input bit b2b);
    fir_xifu_ex2wb_t e, e2;
    x_mem_req_t er;
    n_vec++;
    if (ex_ready !== 1'b1) begin n_err++; $display("FAIL mem_pre_ready: got %b expected 1", ex_ready); end
    drive(instr, rs1_val, imm, $urandom, $urandom, $urandom, $urandom);
    er = exp_req(id2ex);
    tick;
    id_valid = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (ex2wb !== e) begin n_err++; $display("FAIL mem_result: got %h expected %h", ex2wb, e); end
    for (int c = 0; c <= stall; c++) begin
      if (c == stall) begin xif.mem_ready = 1'b1; #1; end
      n_vec++;
      if (xif.mem_valid !== 1'b1 || xif.mem_req !== er || ex_ready !== 1'b0) begin
        n_err++; $display("FAIL mem_req[%0d]: got v=%b req=%h rdy=%b expected v=1 req=%h rdy=0",
                          c, xif.mem_valid, xif.mem_req, ex_ready, er);
      end
      tick;
    end
    xif.mem_ready = 1'b0;
    hs_exp++;
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (xif.mem_valid !== 1'b0 || ex_ready !== 1'b0 || ex2wb !== e) begin
        n_err++; $display("FAIL mem_wait[%0d]: got v=%b rdy=%b wb=%h expected v=0 rdy=0 wb=%h",
                          c, xif.mem_valid, ex_ready, ex2wb, e);
      end
      tick;
    end
    mem_result_valid = 1'b1;
    #1;
    n_vec++;
    if (ex_ready !== 1'b1) begin n_err++; $display("FAIL mem_done_ready: got %b expected 1", ex_ready); end
    if (b2b) begin
      drive(INSTR_XFIRDOTP, $urandom, 12'($urandom), $urandom, $urandom, $urandom, $urandom);
      tick;
      mem_result_valid = 1'b0; id_valid = 1'b0;
      e2 = exp_q.pop_front();
      n_vec++;
      if (ex2wb !== e2 || xif.mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_dotp: got wb=%h v=%b rdy=%b expected wb=%h v=0 rdy=1",
                          ex2wb, xif.mem_valid, ex_ready, e2);
      end
    end else begin
      tick;
      mem_result_valid = 1'b0;
      n_vec++;
      if (ex2wb !== e || ex_ready !== 1'b1) begin
        n_err++; $display("FAIL mem_complete: got wb=%h rdy=%b expected wb=%h rdy=1", ex2wb, ex_ready, e);
      end
    end
    tick;
    n_vec++;
    if (ex2wb.instr !== INSTR_NONE || xif.mem_valid !== 1'b0) begin
      n_err++; $display("FAIL mem_after: got instr=%0d v=%b expected instr=0 v=0", ex2wb.instr, xif.mem_valid);
    end
  endtask

  task automatic test_invalid;
    drive(INSTR_XFIRDOTP, 32'h0, 12'h0, 32'h0001_0001, 32'h0001_0001, 32'h0, 32'h0);
    tick;
    void'(exp_q.pop_front());
    drive(INSTR_NONE, 32'h3000, 12'h4, $urandom, $urandom, $urandom, $urandom);
    tick;
    id_valid = 1'b0;
    n_vec++;
    if (ex2wb.instr !== INSTR_NONE || xif.mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
      n_err++; $display("FAIL invalid_instr: got instr=%0d v=%b rdy=%b expected instr=0 v=0 rdy=1",
                        ex2wb.instr, xif.mem_valid, ex_ready);
    end
    tick;
  endtask

  task automatic test_reset_mid(input bit in_wait);
    drive(INSTR_XFIRLW, 32'h0000_4000, 12'h8, $urandom, $urandom, $urandom, $urandom);
    tick;
    id_valid = 1'b0;
    void'(exp_q.pop_front());
    if (in_wait) begin
      xif.mem_ready = 1'b1;
      hs_exp++;
      tick;
      xif.mem_ready = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (xif.mem_valid !== 1'b0 || ex2wb !== '0 || ex_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid[%0d]: got v=%b wb=%h rdy=%b expected v=0 wb=0 rdy=1",
                        in_wait, xif.mem_valid, ex2wb, ex_ready);
    end
    tick;
    rst_n = 1'b1;
    repeat (2) tick;
    n_vec++;
    if (xif.mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_no_replay[%0d]: got v=%b rdy=%b expected v=0 rdy=1", in_wait, xif.mem_valid, ex_ready);
    end
  endtask

  initial begin
    test_reset;
    test_dotp;
    test_mem(INSTR_XFIRLW, 32'h0000_1000, 12'd4, 3, 1'b0);
    test_mem(INSTR_XFIRSW, $urandom, 12'hFFC, 0, 1'b0);
    test_mem(INSTR_XFIRSW, 32'h0000_2000, 12'd16, 1, 1'b1);
    test_mem(INSTR_XFIRLW, 32'hFFFF_FFFC, 12'd8, 0, 1'b1);
    test_invalid;
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    n_vec++;
    if (hs_cnt !== hs_exp) begin n_err++; $display("FAIL handshake_count: got %0d expected %0d", hs_cnt, hs_exp); end
    n_vec++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
